// File: rtl/lfsr_test_sequencer.sv
// lfsr_test_sequencer: drives an LFSR generator/checker pair through one lock
// test: program seed, soft reset, settle, clean run, corruption burst, verdict.
// Optional macro LFSR_SEQ_RELOCK_EN adds a RELOCK phase after the corruption
// burst (error code 5) and the o_relock_latency output.
// Handshake: i_start is a one-cycle request that is sampled only in IDLE and
// is never queued. o_done is a one-cycle pulse. o_pass, o_err and the latency
// outputs stay valid until the next accepted start.
module lfsr_test_sequencer #(
    parameter int SEED_W        = 8,
    parameter int CNT_W         = 16,
    parameter int SETTLE_CYCLES = 20,
    parameter int LOCK_TIMEOUT  = 64
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic [SEED_W-1:0] i_seed,
    input  logic [CNT_W-1:0]  i_run_len,
    input  logic [CNT_W-1:0]  i_corrupt_len,
    input  logic              i_lock,
    output logic              o_soft_reset,
    output logic              o_valid,
    output logic              o_corrupt,
    output logic [SEED_W-1:0] o_seed,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [2:0]        o_err,
    output logic [CNT_W-1:0]  o_lock_latency,
`ifdef LFSR_SEQ_RELOCK_EN
    output logic [CNT_W-1:0]  o_relock_latency,
`endif
    output logic [2:0]        o_state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_SETTLE  = 3'd2,
        S_RUN     = 3'd3,
        S_CORRUPT = 3'd4,
        S_DONE    = 3'd5
`ifdef LFSR_SEQ_RELOCK_EN
        , S_RELOCK = 3'd6
`endif
    } state_e;

    localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT     = CNT_W'(LOCK_TIMEOUT);

    localparam logic [2:0] ERR_OK      = 3'd0;
    localparam logic [2:0] ERR_NO_LOCK = 3'd1;
    localparam logic [2:0] ERR_LOST    = 3'd2;
    localparam logic [2:0] ERR_KEPT    = 3'd3;
    localparam logic [2:0] ERR_ABORT   = 3'd4;
`ifdef LFSR_SEQ_RELOCK_EN
    localparam logic [2:0] ERR_RELOCK  = 3'd5;
`endif

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    lat_q, lat_d;
    logic                locked_q, locked_d;
    logic                drop_q, drop_d;
    logic [2:0]          err_q, err_d;
    logic                pass_q, pass_d;
    logic [SEED_W-1:0]   seed_q, seed_d;
    logic [CNT_W-1:0]    run_len_q, run_len_d;
    logic [CNT_W-1:0]    corrupt_len_q, corrupt_len_d;
`ifdef LFSR_SEQ_RELOCK_EN
    logic [CNT_W-1:0]    rlat_q, rlat_d;
`endif
    logic                soft_reset_q, valid_q, corrupt_q, busy_q, done_q;
    logic                run_last, corrupt_last;

    // Last cycle of the clean run / corruption burst (cnt_q counts cycles already spent).
    assign run_last     = (cnt_q + ONE == run_len_q);
    assign corrupt_last = (cnt_q + ONE == corrupt_len_q);

    // Next-state, counters and verdict; abort overrides everything except IDLE and DONE.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        lat_d         = lat_q;
        locked_d      = locked_q;
        drop_d        = drop_q;
        err_d         = err_q;
        pass_d        = pass_q;
        seed_d        = seed_q;
        run_len_d     = run_len_q;
        corrupt_len_d = corrupt_len_q;
`ifdef LFSR_SEQ_RELOCK_EN
        rlat_d        = rlat_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    seed_d        = i_seed;
                    run_len_d     = i_run_len;
                    corrupt_len_d = i_corrupt_len;
                    pass_d        = 1'b0;
                    err_d         = ERR_OK;
                    lat_d         = '0;
                    locked_d      = 1'b0;
                    drop_d        = 1'b0;
                    cnt_d         = '0;
`ifdef LFSR_SEQ_RELOCK_EN
                    rlat_d        = '0;
`endif
                    state_d       = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    // A zero-length run can never lock, so skip it entirely.
                    if (run_len_q == '0) begin
                        err_d   = ERR_NO_LOCK;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    cnt_d = cnt_q + ONE;
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + ONE;
                if (locked_q && !i_lock) begin
                    err_d   = ERR_LOST;
                    state_d = S_DONE;
                end else if (!locked_q && !i_lock) begin
                    if (lat_q != CNT_MAX) lat_d = lat_q + ONE;
                    if (lat_d >= TIMEOUT || run_last) begin
                        err_d   = ERR_NO_LOCK;
                        state_d = S_DONE;
                    end
                end else begin
                    locked_d = 1'b1;
                    if (run_last) begin
                        cnt_d   = '0;
                        state_d = (corrupt_len_q == '0) ? S_DONE : S_CORRUPT;
                    end
                end
            end
            S_CORRUPT: begin
                cnt_d = cnt_q + ONE;
                if (!i_lock) drop_d = 1'b1;
                if (corrupt_last) begin
                    cnt_d = '0;
                    if (drop_q || !i_lock) begin
`ifdef LFSR_SEQ_RELOCK_EN
                        state_d = S_RELOCK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        err_d   = ERR_KEPT;
                        state_d = S_DONE;
                    end
                end
            end
`ifdef LFSR_SEQ_RELOCK_EN
            S_RELOCK: begin
                if (i_lock) begin
                    state_d = S_DONE;
                end else begin
                    if (rlat_q != CNT_MAX) rlat_d = rlat_q + ONE;
                    if (rlat_d >= TIMEOUT) begin
                        err_d   = ERR_RELOCK;
                        state_d = S_DONE;
                    end
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // DONE already carries a verdict; aborting there would double the done pulse.
        if (i_abort && state_q != S_IDLE && state_q != S_DONE) begin
            err_d   = ERR_ABORT;
            state_d = S_DONE;
        end
        if (state_d == S_DONE) pass_d = (err_d == ERR_OK);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            lat_q         <= '0;
            locked_q      <= 1'b0;
            drop_q        <= 1'b0;
            err_q         <= ERR_OK;
            pass_q        <= 1'b0;
            seed_q        <= '1;
            run_len_q     <= '0;
            corrupt_len_q <= '0;
`ifdef LFSR_SEQ_RELOCK_EN
            rlat_q        <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            lat_q         <= lat_d;
            locked_q      <= locked_d;
            drop_q        <= drop_d;
            err_q         <= err_d;
            pass_q        <= pass_d;
            seed_q        <= seed_d;
            run_len_q     <= run_len_d;
            corrupt_len_q <= corrupt_len_d;
`ifdef LFSR_SEQ_RELOCK_EN
            rlat_q        <= rlat_d;
`endif
        end
    end

    // Control outputs are registered from the next state so they align with state_q.
    always_ff @(posedge clk or negedge i_rst) begin
        if (!i_rst) begin
            soft_reset_q <= 1'b0;
            valid_q      <= 1'b0;
            corrupt_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            soft_reset_q <= (state_d == S_LOAD);
`ifdef LFSR_SEQ_RELOCK_EN
            valid_q      <= (state_d == S_RUN) || (state_d == S_CORRUPT) || (state_d == S_RELOCK);
`else
            valid_q      <= (state_d == S_RUN) || (state_d == S_CORRUPT);
`endif
            corrupt_q    <= (state_d == S_CORRUPT);
            busy_q       <= (state_d != S_IDLE);
            done_q       <= (state_d == S_DONE);
        end
    end

    assign o_soft_reset     = soft_reset_q;
    assign o_valid          = valid_q;
    assign o_corrupt        = corrupt_q;
    assign o_seed           = seed_q;
    assign o_busy           = busy_q;
    assign o_done           = done_q;
    assign o_pass           = pass_q;
    assign o_err            = err_q;
    assign o_lock_latency   = lat_q;
`ifdef LFSR_SEQ_RELOCK_EN
    assign o_relock_latency = rlat_q;
`endif
    assign o_state_dbg      = state_q;

endmodule

// File: tb/tb_lfsr_test_sequencer.sv
// tb_lfsr_test_sequencer: directed lock-test scenarios for lfsr_test_sequencer
// with a behavioural checker-lock model and an expected-verdict queue.
`timescale 1ns/1ps
module tb_lfsr_test_sequencer;
    localparam int SEED_W = 8;
    localparam int CNT_W  = 16;
    localparam int W      = 1 + 3 + CNT_W + CNT_W;
`ifdef LFSR_SEQ_RELOCK_EN
    localparam int NOM_V  = 26 + 6 + 13;
    localparam int POST_V = 12 + 3 + 13;
`else
    localparam int NOM_V  = 26 + 6;
    localparam int POST_V = 12 + 3;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    logic i_rst, i_start, i_abort, i_lock;
    logic [SEED_W-1:0] i_seed;
    logic [CNT_W-1:0]  i_run_len, i_corrupt_len;
    logic o_soft_reset, o_valid, o_corrupt, o_busy, o_done, o_pass;
    logic [SEED_W-1:0] o_seed;
    logic [2:0]        o_err, o_state_dbg;
    logic [CNT_W-1:0]  o_lock_latency;
`ifdef LFSR_SEQ_RELOCK_EN
    logic [CNT_W-1:0]  o_relock_latency;
`endif

    always #5 clk = ~clk;

    lfsr_test_sequencer #(.SEED_W(SEED_W), .CNT_W(CNT_W), .SETTLE_CYCLES(20), .LOCK_TIMEOUT(64)) dut (
        .clk(clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
        .i_seed(i_seed), .i_run_len(i_run_len), .i_corrupt_len(i_corrupt_len),
        .i_lock(i_lock), .o_soft_reset(o_soft_reset), .o_valid(o_valid),
        .o_corrupt(o_corrupt), .o_seed(o_seed), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_err(o_err), .o_lock_latency(o_lock_latency),
`ifdef LFSR_SEQ_RELOCK_EN
        .o_relock_latency(o_relock_latency),
`endif
        .o_state_dbg(o_state_dbg)
    );

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // ---------------- checker lock model ----------------
    // Lock is high from the lock_at-th clean valid, falls at the drop_at-th
    // corrupted valid and returns at the relock_at-th valid after corruption.
    int lock_at    = 100000;
    int drop_at    = 100000;
    int relock_at  = 100000;
    bit force_lock = 1'b0;
    int run_cnt = 0, cor_cnt = 0, post_cnt = 0;

    initial begin
        i_lock = 1'b0;
        forever begin
            @(negedge clk);
            if (!i_rst || o_soft_reset) begin
                run_cnt = 0; cor_cnt = 0; post_cnt = 0;
                i_lock = force_lock;
            end else if (force_lock) begin
                i_lock = 1'b1;
            end else if (o_valid && o_corrupt) begin
                i_lock = (cor_cnt < drop_at);
                cor_cnt++;
            end else if (o_valid && cor_cnt == 0) begin
                i_lock = (run_cnt >= lock_at);
                run_cnt++;
            end else if (o_valid) begin
                i_lock = (post_cnt >= relock_at);
                post_cnt++;
            end
        end
    end

    // ---------------- output monitor ----------------
    int done_cnt = 0;
    int sr_cnt = 0, v_cnt = 0, c_cnt = 0, since_sr = 0, gap = -1;
    bit gap_arm = 1'b0;
    logic              d_pass;
    logic [2:0]        d_err;
    logic [CNT_W-1:0]  d_lat, d_rlat;
    int d_sr, d_v, d_c, d_gap;

    initial begin
        forever begin
            @(negedge clk);
            if (!i_rst) begin
                sr_cnt = 0; v_cnt = 0; c_cnt = 0; since_sr = 0; gap = -1; gap_arm = 1'b0;
            end else begin
                if (o_soft_reset) begin
                    sr_cnt++; since_sr = 0; gap_arm = 1'b1;
                end else if (gap_arm) begin
                    if (o_valid) begin gap = since_sr; gap_arm = 1'b0; end
                    else since_sr++;
                end
                if (o_valid) v_cnt++;
                if (o_corrupt) c_cnt++;
                if (o_done) begin
                    d_pass = o_pass; d_err = o_err; d_lat = o_lock_latency;
`ifdef LFSR_SEQ_RELOCK_EN
                    d_rlat = o_relock_latency;
`else
                    d_rlat = '0;
`endif
                    d_sr = sr_cnt; d_v = v_cnt; d_c = c_cnt; d_gap = gap;
                    sr_cnt = 0; v_cnt = 0; c_cnt = 0; gap = -1; gap_arm = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    // ---------------- driver / scoreboard tasks ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input bit p, input int err, input int lat, input int rlat);
        return {p, 3'(err), CNT_W'(lat), CNT_W'(rlat)};
    endfunction

    // Called at posedge+1; the start is sampled on the next posedge (LOAD follows).
    task automatic start_test(input logic [SEED_W-1:0] seed, input int rl, input int cl,
                              input bit push, input logic [W-1:0] e, input bit ab);
        i_start = 1'b1; i_abort = ab;
        i_seed = seed; i_run_len = CNT_W'(rl); i_corrupt_len = CNT_W'(cl);
        if (push) exp_q.push_back(e);
        @(posedge clk); #1;
        i_start = 1'b0; i_abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start_cnt;
        int n;
        logic [W-1:0] e;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != start_cnt), 1);
        if (done_cnt != start_cnt && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_pass"}, 32'(d_pass), 32'(e[W-1]));
            check({tag, "_err"}, 32'(d_err), 32'(e[W-2 -: 3]));
            check({tag, "_lock_latency"}, 32'(d_lat), 32'(e[2*CNT_W-1 -: CNT_W]));
`ifdef LFSR_SEQ_RELOCK_EN
            check({tag, "_relock_latency"}, 32'(d_rlat), 32'(e[CNT_W-1:0]));
`endif
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int saved_done;
        i_rst = 1'b0; i_start = 1'b0; i_abort = 1'b0;
        i_seed = '0; i_run_len = '0; i_corrupt_len = '0;
        repeat (3) @(posedge clk); #1;
        check("rst_busy", 32'(o_busy), 0);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_done", 32'(o_done), 0);
        check("rst_soft_reset", 32'(o_soft_reset), 0);
        check("rst_corrupt", 32'(o_corrupt), 0);
        check("rst_pass", 32'(o_pass), 0);
        check("rst_err", 32'(o_err), 0);
        check("rst_lat", 32'(o_lock_latency), 0);
        check("rst_seed", 32'(o_seed), 32'hFF);
        check("rst_state", 32'(o_state_dbg), 0);
        i_rst = 1'b1;
        @(posedge clk); #1;

        // abort in IDLE is ignored
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("idle_abort_busy", 32'(o_busy), 0);
        check("idle_abort_done", 32'(o_done), 0);

        // nominal lock test
        lock_at = 10; drop_at = 2; relock_at = 12; force_lock = 1'b0;
        start_test(8'hFF, 26, 6, 1'b1, mk(1'b1, 0, 10, 12), 1'b0);
        check("nom_load_soft_reset", 32'(o_soft_reset), 1);
        check("nom_load_busy", 32'(o_busy), 1);
        check("nom_load_valid", 32'(o_valid), 0);
        wait_done("nom", 300);
        check("nom_soft_reset_cycles", 32'(d_sr), 1);
        check("nom_settle_gap", 32'(d_gap), 20);
        check("nom_valid_cycles", 32'(d_v), 32'(NOM_V));
        check("nom_corrupt_cycles", 32'(d_c), 6);
        check("nom_pass_held", 32'(o_pass), 1);
        check("nom_busy_after", 32'(o_busy), 0);
        check("nom_done_after", 32'(o_done), 0);

        // lock never acquired, with an ignored start while busy
        lock_at = 100000;
        start_test(8'h3C, 100, 6, 1'b1, mk(1'b0, 1, 64, 0), 1'b0);
        check("nolock_seed", 32'(o_seed), 32'h3C);
        repeat (3) @(posedge clk); #1;
        i_start = 1'b1; i_seed = 8'h00;
        @(posedge clk); #1;
        i_start = 1'b0;
        check("busy_start_seed", 32'(o_seed), 32'h3C);
        check("busy_start_busy", 32'(o_busy), 1);
        wait_done("nolock", 300);
        check("nolock_valid_cycles", 32'(d_v), 64);
        check("nolock_corrupt_cycles", 32'(d_c), 0);
        check("nolock_soft_reset_cycles", 32'(d_sr), 1);

        // lock held through corruption
        force_lock = 1'b1;
        start_test(8'hC3, 26, 6, 1'b1, mk(1'b0, 3, 0, 0), 1'b0);
        wait_done("held", 300);
        check("held_valid_cycles", 32'(d_v), 32);
        check("held_corrupt_cycles", 32'(d_c), 6);
        force_lock = 1'b0;

        // start and abort together in IDLE: start wins; corrupt_len=0 skips CORRUPT
        lock_at = 3;
        start_test(8'h96, 8, 0, 1'b1, mk(1'b1, 0, 3, 0), 1'b1);
        check("start_abort_soft_reset", 32'(o_soft_reset), 1);
        check("start_abort_seed", 32'(o_seed), 32'h96);
        wait_done("nocorrupt", 300);
        check("nocorrupt_valid_cycles", 32'(d_v), 8);
        check("nocorrupt_corrupt_cycles", 32'(d_c), 0);

        // abort in RUN cycle 5
        lock_at = 10;
        start_test(8'h5A, 26, 6, 1'b1, mk(1'b0, 4, 6, 0), 1'b0);
        n = 0;
        while (!o_valid && n < 100) begin @(posedge clk); #1; n++; end
        check("abort_run_reached", 32'(o_valid), 1);
        repeat (5) @(posedge clk); #1;
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check("abort_valid_drop", 32'(o_valid), 0);
        check("abort_done_pulse", 32'(o_done), 1);
        check("abort_err_now", 32'(o_err), 4);
        wait_done("abort", 10);
        check("abort_valid_cycles", 32'(d_v), 6);

        // new start on the cycle after DONE; run_len=0 fails without any valid
        start_test(8'h21, 0, 4, 1'b1, mk(1'b0, 1, 0, 0), 1'b0);
        check("after_abort_soft_reset", 32'(o_soft_reset), 1);
        wait_done("zero_run", 100);
        check("zero_run_valid_cycles", 32'(d_v), 0);

        // async reset during CORRUPT
        lock_at = 10; drop_at = 2; relock_at = 12;
        start_test(8'hE7, 26, 6, 1'b0, mk(1'b0, 0, 0, 0), 1'b0);
        n = 0;
        while (!o_corrupt && n < 200) begin @(posedge clk); #1; n++; end
        check("rst_mid_reached_corrupt", 32'(o_corrupt), 1);
        saved_done = done_cnt;
        #2;
        i_rst = 1'b0;
        #1;
        check("rst_mid_valid", 32'(o_valid), 0);
        check("rst_mid_corrupt", 32'(o_corrupt), 0);
        check("rst_mid_busy", 32'(o_busy), 0);
        check("rst_mid_seed", 32'(o_seed), 32'hFF);
        check("rst_mid_lat", 32'(o_lock_latency), 0);
        check("rst_mid_state", 32'(o_state_dbg), 0);
        repeat (3) @(posedge clk); #1;
        i_rst = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("rst_mid_no_done", 32'(done_cnt), 32'(saved_done));

        // normal test after reset
        lock_at = 10; drop_at = 0; relock_at = 12;
        start_test(8'h4B, 12, 3, 1'b1, mk(1'b1, 0, 10, 12), 1'b0);
        wait_done("post_rst", 300);
        check("post_rst_valid_cycles", 32'(d_v), 32'(POST_V));
        check("post_rst_corrupt_cycles", 32'(d_c), 3);

`ifdef LFSR_SEQ_RELOCK_EN
        // lock never regained after corruption
        lock_at = 5; drop_at = 0; relock_at = 100000;
        start_test(8'h11, 10, 4, 1'b1, mk(1'b0, 5, 5, 64), 1'b0);
        wait_done("relock_timeout", 300);
        check("relock_timeout_valid_cycles", 32'(d_v), 78);
`endif

        check("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfsr_test_sequencer.md
Name: lfsr_test_sequencer

Overview:
Test controller that drives the LFSR generator/checker pair (the top with i_soft_reset/i_valid/i_seed/i_corrupt/o_lock) through a complete lock test.
- Sequence per test: program seed, soft-reset, settle, clean run, corruption burst, verdict.
- Replaces hand-written bench stimulus. Gives firmware and benches a single start/done/pass interface per test.

Parameters:
SEED_W, 8, seed width (matches generator seed port)
CNT_W, 16, width of run/corrupt length and latency counters
SETTLE_CYCLES, 20, idle cycles (valid low) between soft reset and first valid
LOCK_TIMEOUT, 64, max valid cycles allowed for lock acquire/loss

Ports:
clk  in  1  system clock, rising edge
i_rst  in  1  asynchronous, active-low reset (0 = reset)
i_start  in  1  one-cycle request to start a test; honoured only in IDLE
i_abort  in  1  abort current test
i_seed  in  SEED_W  seed, captured on accepted start
i_run_len  in  CNT_W  clean valid cycles, captured on start
i_corrupt_len  in  CNT_W  corrupted valid cycles, captured on start
i_lock  in  1  checker lock status
o_soft_reset  out  1  to generator/checker soft reset
o_valid  out  1  to generator/checker valid
o_corrupt  out  1  to corruption injector
o_seed  out  SEED_W  seed to generator, held stable for the whole test
o_busy  out  1  high from LOAD through DONE inclusive
o_done  out  1  one-cycle pulse, verdict valid
o_pass  out  1  verdict, held until next accepted start
o_err  out  3  0 ok, 1 no lock, 2 lock lost in RUN, 3 lock kept through corruption, 4 aborted
o_lock_latency  out  CNT_W  valid cycles from RUN entry to first i_lock=1; saturates at all-ones

Behaviour:
- Reset (i_rst=0, async): state IDLE. All outputs 0, except o_seed = all-ones.
- States: IDLE, LOAD, SETTLE, RUN, CORRUPT, DONE. All outputs registered.
- IDLE: on i_start=1, capture seed and lengths; clear o_pass, o_err and o_lock_latency; go to LOAD next cycle.
- LOAD: exactly 1 cycle, o_soft_reset=1, o_seed = captured seed; then SETTLE.
- SETTLE: SETTLE_CYCLES cycles with o_valid=0; then RUN.
- RUN:
  - o_valid=1 for run_len cycles; the lock-latency counter increments each RUN cycle until i_lock is first seen high.
  - If lock is not seen within LOCK_TIMEOUT cycles, or RUN ends unlocked: err=1, go to DONE.
  - If lock is seen and then i_lock drops before RUN ends: err=2, go to DONE.
  - run_len=0: err=1 immediately (no lock possible).
- CORRUPT:
  - o_valid=1 and o_corrupt=1 for corrupt_len cycles.
  - Pass requires i_lock=0 on at least one CORRUPT cycle; otherwise err=3.
  - corrupt_len=0: CORRUPT is skipped, and RUN success alone is a pass.
- DONE: 1 cycle; o_done=1, o_valid=0, o_corrupt=0; o_pass = (err==0); then IDLE.
- i_abort (any non-IDLE state, highest priority): next cycle is DONE with err=4, pass=0, and o_valid/o_corrupt drop that same cycle. i_abort in IDLE is ignored.
- i_start while busy: ignored, no queuing.
- Simultaneous i_start and i_abort in IDLE: the start is accepted.
- Async reset mid-test: immediate return to reset values; no o_done pulse.
- Counters use CNT_W-bit unsigned arithmetic; the latency counter saturates and does not wrap.

Optional Feature:
LFSR_SEQ_RELOCK_EN
- Defined:
  - Adds state RELOCK between CORRUPT and DONE, entered only if corruption caused loss of lock.
  - In RELOCK: o_valid=1, o_corrupt=0 until i_lock=1 (pass) or LOCK_TIMEOUT cycles elapse (err=5, pass=0).
  - Adds output o_relock_latency (CNT_W) counting RELOCK cycles.
- Undefined: RELOCK, code 5 and o_relock_latency do not exist; CORRUPT goes directly to DONE.

Test Plan:
- Nominal lock test: seed=8'hFF, run_len=26, corrupt_len=6, checker locks after 10 valids and drops during corruption -> exactly one o_soft_reset cycle; first o_valid 20 cycles later; o_done with o_pass=1, o_err=0, o_lock_latency=10.
- Lock never acquired: i_lock tied 0, run_len=100 -> o_done after 64 RUN cycles; o_pass=0, o_err=1, o_lock_latency=16'hFFFF not reached (equals 64).
- Lock held through corruption: i_lock stays 1 for the whole test, corrupt_len=6 -> o_pass=0, o_err=3, o_valid high for exactly 26+6 cycles.
- Abort during RUN cycle 5 -> o_valid low on the next cycle; o_done with o_err=4; a new i_start is accepted on the following cycle.
- Async reset asserted in CORRUPT -> all outputs return to reset values immediately, o_seed=8'hFF, no o_done; a new test then runs normally.
- With LFSR_SEQ_RELOCK_EN defined: lock is regained 12 cycles after corruption ends -> o_pass=1, o_relock_latency=12. If lock is never regained -> o_err=5 after 64 cycles.
